// File: rtl/ram_arb_pkg.sv
// Shared definitions for the two-port RAM arbiter.
// Contents: default RAM geometry, the sequencer state encoding and the
// requester identifiers used for owner/last_grant.
package ram_arb_pkg;

  localparam int ADDR_W_DFLT = 7;
  localparam int DATA_W_DFLT = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } arb_state_e;

  localparam logic PORT_A = 1'b0;
  localparam logic PORT_B = 1'b1;

endpackage

// File: rtl/rr_arb2.sv
// Combinational two-way round-robin picker.
// Ports:
//   req_a, req_b : pending requests from ports A and B
//   last_grant   : port that won the previous arbitration
//   gnt_valid    : at least one request is pending
//   gnt_id       : winning port (PORT_A / PORT_B)
module rr_arb2
  import ram_arb_pkg::*;
(
  input  logic req_a,
  input  logic req_b,
  input  logic last_grant,
  output logic gnt_valid,
  output logic gnt_id
);

  // A lone request always wins; a tie goes to the port that was not
  // served last, so a continuously requesting port cannot starve the other.
  always_comb begin
    gnt_valid = req_a | req_b;
    gnt_id    = PORT_A;
    if (req_a && req_b) begin
      gnt_id = ~last_grant;
    end else if (req_b) begin
      gnt_id = PORT_B;
    end
  end

endmodule

// File: rtl/ram_arbiter.sv
// Round-robin arbiter and sequencer in front of a single-port synchronous RAM.
// Serialises read/write commands from requesters A and B into single-cycle
// en/we pulses, waits out the RAM read latency and returns data with a
// one-cycle ack to the requester that was served.
// Ports:
//   clk, rst                 : clock, asynchronous active-low reset
//   req_x/we_x/addr_x/wdata_x: command from requester x (held until ack_x)
//   ack_x/rdata_x            : completion pulse and read data for requester x
//   ram_in/ram_addr/ram_en/ram_we/ram_rst : registered RAM controls
//   ram_out                  : RAM read data
//   busy                     : sequencer not in IDLE
//   owner                    : port being served (holds last value in IDLE)
module ram_arbiter
  import ram_arb_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DFLT,
  parameter int DATA_W = DATA_W_DFLT,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_a,
  input  logic              we_a,
  input  logic [ADDR_W-1:0] addr_a,
  input  logic [DATA_W-1:0] wdata_a,
  output logic              ack_a,
  output logic [DATA_W-1:0] rdata_a,
  input  logic              req_b,
  input  logic              we_b,
  input  logic [ADDR_W-1:0] addr_b,
  input  logic [DATA_W-1:0] wdata_b,
  output logic              ack_b,
  output logic [DATA_W-1:0] rdata_b,
  output logic [DATA_W-1:0] ram_in,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_en,
  output logic              ram_we,
  output logic              ram_rst,
  input  logic [DATA_W-1:0] ram_out,
  output logic              busy,
  output logic              owner
);

  localparam logic [2:0] RD_LAT_C = 3'(RD_LAT);

  arb_state_e        state_q, state_d;
  logic              cmd_we_q, cmd_we_d;
  logic [ADDR_W-1:0] cmd_addr_q, cmd_addr_d;
  logic [DATA_W-1:0] cmd_wdata_q, cmd_wdata_d;
  logic              owner_q, owner_d;
  logic              last_grant_q, last_grant_d;
  logic [2:0]        cnt_q, cnt_d;
  logic [DATA_W-1:0] rdata_a_q, rdata_a_d;
  logic [DATA_W-1:0] rdata_b_q, rdata_b_d;
  logic              ack_a_q, ack_a_d;
  logic              ack_b_q, ack_b_d;
  logic              ram_en_q, ram_en_d;
  logic              ram_we_q, ram_we_d;
  logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
  logic [DATA_W-1:0] ram_in_q, ram_in_d;
  logic              ram_rst_q;

  logic gnt_valid;
  logic gnt_id;

  rr_arb2 u_rr_arb2 (
    .req_a      (req_a),
    .req_b      (req_b),
    .last_grant (last_grant_q),
    .gnt_valid  (gnt_valid),
    .gnt_id     (gnt_id)
  );

  // Next-state logic. Outputs are derived from the *next* state so that
  // the registered RAM controls and acks line up with the state they
  // belong to, rather than lagging it by one cycle.
  always_comb begin
    state_d      = state_q;
    cmd_we_d     = cmd_we_q;
    cmd_addr_d   = cmd_addr_q;
    cmd_wdata_d  = cmd_wdata_q;
    owner_d      = owner_q;
    last_grant_d = last_grant_q;
    cnt_d        = cnt_q;
    rdata_a_d    = rdata_a_q;
    rdata_b_d    = rdata_b_q;

    unique case (state_q)
      IDLE: begin
        if (gnt_valid) begin
          owner_d      = gnt_id;
          last_grant_d = gnt_id;
          cmd_we_d     = (gnt_id == PORT_B) ? we_b    : we_a;
          cmd_addr_d   = (gnt_id == PORT_B) ? addr_b  : addr_a;
          cmd_wdata_d  = (gnt_id == PORT_B) ? wdata_b : wdata_a;
          state_d      = ISSUE;
        end
      end
      ISSUE: begin
        if (cmd_we_q) begin
          state_d = RESP;
        end else begin
          cnt_d   = RD_LAT_C;
          state_d = WAIT;
        end
      end
      WAIT: begin
        // The last WAIT edge is the first one at which ram_out is valid.
        if (cnt_q == 3'd1) begin
          if (owner_q == PORT_B) begin
            rdata_b_d = ram_out;
          end else begin
            rdata_a_d = ram_out;
          end
          state_d = RESP;
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    ram_en_d   = (state_d == ISSUE);
    ram_we_d   = (state_d == ISSUE) && cmd_we_d;
    ram_addr_d = (state_d == ISSUE) ? cmd_addr_d : '0;
    ram_in_d   = ((state_d == ISSUE) && cmd_we_d) ? cmd_wdata_d : '0;
    ack_a_d    = (state_d == RESP) && (owner_d == PORT_A);
    ack_b_d    = (state_d == RESP) && (owner_d == PORT_B);
  end

  // State and output registers. ram_rst is held high through reset and
  // cleared by the first edge after release, so the RAM sees exactly one
  // reset edge once the clock runs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      cmd_we_q     <= 1'b0;
      cmd_addr_q   <= '0;
      cmd_wdata_q  <= '0;
      owner_q      <= PORT_A;
      last_grant_q <= PORT_B;
      cnt_q        <= 3'd0;
      rdata_a_q    <= '0;
      rdata_b_q    <= '0;
      ack_a_q      <= 1'b0;
      ack_b_q      <= 1'b0;
      ram_en_q     <= 1'b0;
      ram_we_q     <= 1'b0;
      ram_addr_q   <= '0;
      ram_in_q     <= '0;
      ram_rst_q    <= 1'b1;
    end else begin
      state_q      <= state_d;
      cmd_we_q     <= cmd_we_d;
      cmd_addr_q   <= cmd_addr_d;
      cmd_wdata_q  <= cmd_wdata_d;
      owner_q      <= owner_d;
      last_grant_q <= last_grant_d;
      cnt_q        <= cnt_d;
      rdata_a_q    <= rdata_a_d;
      rdata_b_q    <= rdata_b_d;
      ack_a_q      <= ack_a_d;
      ack_b_q      <= ack_b_d;
      ram_en_q     <= ram_en_d;
      ram_we_q     <= ram_we_d;
      ram_addr_q   <= ram_addr_d;
      ram_in_q     <= ram_in_d;
      ram_rst_q    <= 1'b0;
    end
  end

  assign ack_a    = ack_a_q;
  assign ack_b    = ack_b_q;
  assign rdata_a  = rdata_a_q;
  assign rdata_b  = rdata_b_q;
  assign ram_en   = ram_en_q;
  assign ram_we   = ram_we_q;
  assign ram_addr = ram_addr_q;
  assign ram_in   = ram_in_q;
  assign ram_rst  = ram_rst_q;
  assign busy     = (state_q != IDLE);
  assign owner    = owner_q;

endmodule

// File: tb/tb_ram_arbiter.sv
// Bench for ram_arbiter: a behavioural 128x8 synchronous RAM hangs off the
// RAM port, and a transaction-level reference (memory array, per-port read
// data, round-robin winner rule, latency formula) supplies every expectation.
module tb_ram_arbiter;

  localparam int ADDR_W = 7;
  localparam int DATA_W = 8;
  localparam int RD_LAT = 1;

  logic              clk = 1'b0;
  logic              rst;
  logic              req_a, we_a, req_b, we_b;
  logic [ADDR_W-1:0] addr_a, addr_b;
  logic [DATA_W-1:0] wdata_a, wdata_b;
  logic              ack_a, ack_b;
  logic [DATA_W-1:0] rdata_a, rdata_b;
  logic [DATA_W-1:0] ram_in, ram_out;
  logic [ADDR_W-1:0] ram_addr;
  logic              ram_en, ram_we, ram_rst;
  logic              busy, owner;

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [DATA_W-1:0] refMem [128];
  logic [DATA_W-1:0] refRd  [2];
  int                refLast;

  // Pending commands per port (0 = A, 1 = B)
  logic              pend  [2];
  logic              cWe   [2];
  logic [ADDR_W-1:0] cAddr [2];
  logic [DATA_W-1:0] cData [2];

  ram_arbiter #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .RD_LAT (RD_LAT)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .req_a    (req_a),
    .we_a     (we_a),
    .addr_a   (addr_a),
    .wdata_a  (wdata_a),
    .ack_a    (ack_a),
    .rdata_a  (rdata_a),
    .req_b    (req_b),
    .we_b     (we_b),
    .addr_b   (addr_b),
    .wdata_b  (wdata_b),
    .ack_b    (ack_b),
    .rdata_b  (rdata_b),
    .ram_in   (ram_in),
    .ram_addr (ram_addr),
    .ram_en   (ram_en),
    .ram_we   (ram_we),
    .ram_rst  (ram_rst),
    .ram_out  (ram_out),
    .busy     (busy),
    .owner    (owner)
  );

  always #5 clk = ~clk;

  // Behavioural RAM: synchronous active-high reset clears contents, read
  // data emerges RD_LAT edges after the edge that samples en & ~we.
  logic [DATA_W-1:0] ramMem  [128];
  logic [DATA_W-1:0] ramPipe [RD_LAT];

  always @(posedge clk) begin
    if (ram_rst) begin
      for (int i = 0; i < 128; i++) ramMem[i] <= '0;
      for (int j = 0; j < RD_LAT; j++) ramPipe[j] <= '0;
    end else begin
      if (ram_en && ram_we) ramMem[ram_addr] <= ram_in;
      if (ram_en && !ram_we) ramPipe[0] <= ramMem[ram_addr];
      for (int j = 1; j < RD_LAT; j++) ramPipe[j] <= ramPipe[j-1];
    end
  end

  assign ram_out = ramPipe[RD_LAT-1];

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus();
    req_a   = pend[0];
    we_a    = cWe[0];
    addr_a  = cAddr[0];
    wdata_a = cData[0];
    req_b   = pend[1];
    we_b    = cWe[1];
    addr_b  = cAddr[1];
    wdata_b = cData[1];
  endtask

  task automatic setCmd(input int p, input logic we, input logic [ADDR_W-1:0] a,
                        input logic [DATA_W-1:0] d);
    pend[p]  = 1'b1;
    cWe[p]   = we;
    cAddr[p] = a;
    cData[p] = d;
  endtask

  task automatic resetModel();
    for (int i = 0; i < 128; i++) refMem[i] = '0;
    refRd[0] = '0;
    refRd[1] = '0;
    refLast  = 1;
    for (int p = 0; p < 2; p++) begin
      pend[p] = 1'b0; cWe[p] = 1'b0; cAddr[p] = '0; cData[p] = '0;
    end
  endtask

  // Serve one grant, starting at a negedge in an IDLE cycle and ending at
  // the negedge of the following IDLE cycle. holdReq keeps the winner's
  // request asserted so it re-arbitrates as a fresh command.
  task automatic runGrant(input bit holdReq);
    int w;
    int lat;
    if (pend[0] && pend[1]) w = (refLast == 0) ? 1 : 0;
    else                    w = pend[1] ? 1 : 0;
    lat = cWe[w] ? 2 : 2 + RD_LAT;
    applyStimulus();
    for (int k = 1; k <= lat; k++) begin
      @(negedge clk);
      if (k == 1) begin
        checkOutput("ram_en_issue", ram_en, 1);
        checkOutput("ram_we_issue", ram_we, cWe[w]);
        checkOutput("ram_addr_issue", ram_addr, cAddr[w]);
        checkOutput("ram_in_issue", ram_in, cWe[w] ? cData[w] : 0);
        checkOutput("owner_issue", owner, w);
        checkOutput("busy_issue", busy, 1);
      end else begin
        checkOutput("ram_en_quiet", ram_en, 0);
        checkOutput("ram_addr_quiet", ram_addr, 0);
      end
      checkOutput(w ? "ack_b_win" : "ack_a_win", w ? ack_b : ack_a, (k == lat) ? 1 : 0);
      checkOutput(w ? "ack_a_lose" : "ack_b_lose", w ? ack_a : ack_b, 0);
    end
    refLast = w;
    if (cWe[w]) refMem[cAddr[w]] = cData[w];
    else        refRd[w] = refMem[cAddr[w]];
    checkOutput("rdata_a", rdata_a, refRd[0]);
    checkOutput("rdata_b", rdata_b, refRd[1]);
    if (!holdReq) begin
      pend[w] = 1'b0;
      applyStimulus();
    end
    @(negedge clk);
    checkOutput("busy_idle", busy, 0);
    checkOutput("owner_hold", owner, w);
  endtask

  initial begin
    resetModel();
    applyStimulus();
    rst = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_ack_a", ack_a, 0);
    checkOutput("rst_ack_b", ack_b, 0);
    checkOutput("rst_ram_en", ram_en, 0);
    checkOutput("rst_ram_rst", ram_rst, 1);
    checkOutput("rst_rdata_a", rdata_a, 0);
    rst = 1'b1;
    #1;
    checkOutput("ram_rst_after_release", ram_rst, 1);
    @(negedge clk);
    checkOutput("ram_rst_cleared", ram_rst, 0);

    $display("[TB] A writes 0x55 to addr 2, B reads it back");
    setCmd(0, 1'b1, 7'd2, 8'h55);
    runGrant(1'b0);
    setCmd(1, 1'b0, 7'd2, 8'h00);
    runGrant(1'b0);

    $display("[TB] contention: both ports writing continuously");
    setCmd(0, 1'b1, 7'd5, 8'h14);
    setCmd(1, 1'b1, 7'd19, 8'h42);
    for (int i = 0; i < 4; i++) runGrant(i < 3);
    setCmd(0, 1'b0, 7'd19, 8'h00);
    setCmd(1, 1'b0, 7'd5, 8'h00);
    runGrant(1'b0);
    runGrant(1'b0);

    $display("[TB] top address boundary");
    setCmd(0, 1'b1, 7'd127, 8'hFF);
    runGrant(1'b0);
    setCmd(1, 1'b0, 7'd127, 8'h00);
    runGrant(1'b0);
    setCmd(0, 1'b0, 7'd0, 8'h00);
    runGrant(1'b0);

    $display("[TB] randomized traffic");
    for (int it = 0; it < 80; it++) begin
      for (int p = 0; p < 2; p++) begin
        if (!pend[p] && $urandom_range(0, 2) != 0) begin
          setCmd(p, 1'($urandom_range(0, 1)),
                 ($urandom_range(0, 3) == 0) ? 7'($urandom) : 7'($urandom_range(0, 7)),
                 8'($urandom));
        end
      end
      if (!pend[0] && !pend[1]) begin
        applyStimulus();
        @(negedge clk);
        checkOutput("busy_no_req", busy, 0);
      end else begin
        runGrant(1'b0);
      end
    end

    $display("[TB] reset during a read wait");
    pend[0] = 1'b0;
    setCmd(1, 1'b0, 7'd19, 8'h00);
    applyStimulus();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    checkOutput("midrst_busy", busy, 0);
    checkOutput("midrst_ack_a", ack_a, 0);
    checkOutput("midrst_ack_b", ack_b, 0);
    checkOutput("midrst_rdata_a", rdata_a, 0);
    checkOutput("midrst_rdata_b", rdata_b, 0);
    checkOutput("midrst_ram_rst", ram_rst, 1);
    checkOutput("midrst_ram_en", ram_en, 0);
    resetModel();
    applyStimulus();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checkOutput("midrst_ack_b_after", ack_b, 0);
    checkOutput("midrst_ram_rst_cleared", ram_rst, 0);

    setCmd(0, 1'b0, 7'd19, 8'h00);
    runGrant(1'b0);
    setCmd(1, 1'b0, 7'd5, 8'h00);
    runGrant(1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
